log_capture: RTL

LOG_CAPTURE -- requirements
Module: log_capture

---
 rtl/log_capture_pkg.sv | 14 +
 rtl/log_capture_ram.sv | 31 +++
 rtl/log_capture.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/log_capture_pkg.sv
// Shared types and defaults for the log capture block.
// Holds the capture FSM state encoding and the default buffer geometry.
package log_capture_pkg;

  localparam int DEFAULT_DEPTH = 1024;
  localparam int DEFAULT_DEC_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/log_capture_ram.sv
// Simple dual-port DEPTH x 32 buffer: synchronous write, registered read.
// Contents are undefined after reset; the capture logic never reads unwritten words.
module log_capture_ram #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // NOTE: the array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/log_capture.sv
// One-shot decimating capture of the RX log stream into a buffer,
// followed by a pop-style readout; arm with start, drain with rd_en.
module log_capture
  import log_capture_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int DEC_W = DEFAULT_DEC_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      S_AXIS_LOG_tdata,
  input  logic             S_AXIS_LOG_tvalid,
  input  logic [DEC_W-1:0] cfg_decim,
  input  logic [AW:0]      cfg_len,
  input  logic             start,
  input  logic             rd_en,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [DEC_W-1:0] decim_q, decim_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             first_q, first_d;
  logic [AW:0]      len_q, len_d;
  logic [AW:0]      wr_cnt_q, wr_cnt_d;
  logic [AW:0]      rd_cnt_q, rd_cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_hold_q;
  logic             arm;
  logic             ram_we;
  logic             ram_re;
  logic [31:0]      ram_rdata;

  // Counters are one bit wider than the pointers so a full buffer is distinguishable from empty.
  assign arm = start && (state_q != CAPTURE);

  always_comb begin
    state_d    = state_q;
    decim_d    = decim_q;
    dec_cnt_d  = dec_cnt_q;
    first_d    = first_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    rd_valid_d = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    unique case (state_q)
      IDLE: ;
      CAPTURE: begin
        if (S_AXIS_LOG_tvalid) begin
          // The first beat after arming is always kept; later beats wait for the counter.
          if (first_q || (dec_cnt_q == decim_q)) begin
            ram_we    = 1'b1;
            wr_cnt_d  = wr_cnt_q + (AW+1)'(1);
            dec_cnt_d = '0;
            first_d   = 1'b0;
            if (wr_cnt_d == len_q) begin
              state_d = DONE;
            end
          end else begin
            dec_cnt_d = dec_cnt_q + DEC_W'(1);
          end
        end
      end
      DONE: begin
        if (!start && rd_en && (rd_cnt_q < wr_cnt_q)) begin
          ram_re     = 1'b1;
          rd_valid_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + (AW+1)'(1);
          if (rd_cnt_d == wr_cnt_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Arming overrides everything above, including a readout in progress.
    if (arm) begin
      state_d   = CAPTURE;
      decim_d   = cfg_decim;
      len_d     = ((cfg_len == '0) || (cfg_len > FULL_LEN)) ? FULL_LEN : cfg_len;
      dec_cnt_d = '0;
      first_d   = 1'b1;
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      decim_q    <= '0;
      dec_cnt_q  <= '0;
      first_q    <= 1'b0;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      decim_q    <= decim_d;
      dec_cnt_q  <= dec_cnt_d;
      first_q    <= first_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_valid_q <= rd_valid_d;
      if (rd_valid_q) begin
        rd_hold_q <= ram_rdata;
      end
    end
  end

  log_capture_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_cnt_q[AW-1:0]),
    .wdata(S_AXIS_LOG_tdata),
    .re   (ram_re),
    .raddr(rd_cnt_q[AW-1:0]),
    .rdata(ram_rdata)
  );

  // The RAM output register is not reset, so a reset-cleared copy supplies the held value.
  assign rd_data  = rd_valid_q ? ram_rdata : rd_hold_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CAPTURE);
  assign done     = (state_q == DONE);
  assign count    = wr_cnt_q;

endmodule
